// File: rtl/omsp_spm_key_loader_pkg.sv
// -----------------------------------------------------------------------------
// omsp_spm_key_loader_pkg
//
// Shared definitions for the SPM key loader:
//   - SPM_SECURITY : key width in bits used by the SPM array (default SECURITY)
//   - KEY_WORDS    : number of 16-bit words per key
//   - KL_TIMEOUT   : default idle-cycle budget while waiting for key words
//   - TIMER_W      : width of the idle-cycle counter
//   - kl_state_t   : loader FSM state encoding (IDLE=0, REQ=1, LOAD=2, DONE=3)
//   - key_words()  : words per key for a given key width
//   - word_is_legal(): a received word is acceptable only when its kd_last
//                      flag agrees with whether it occupies the final slot
// -----------------------------------------------------------------------------
package omsp_spm_key_loader_pkg;

  localparam int SPM_SECURITY = 64;
  localparam int KL_TIMEOUT   = 255;
  localparam int TIMER_W      = 8;

  function automatic int key_words(input int security);
    return security / 16;
  endfunction

  localparam int KEY_WORDS = key_words(SPM_SECURITY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } kl_state_t;

  // A word marked last must land in the final slot, and the final slot
  // must carry the last marker; any disagreement is a malformed key stream.
  function automatic logic word_is_legal(input logic is_last, input logic last_slot);
    return is_last == last_slot;
  endfunction

endpackage

// File: rtl/omsp_spm_key_loader.sv
// -----------------------------------------------------------------------------
// omsp_spm_key_loader
//
// After a protect operation, requests a freshly derived key for the new SM
// from the key-derivation unit and streams its 16-bit words into the SPM
// array key write port, one word per cycle. Reports done or error.
//
// Ports:
//   mclk, puc_rst_n      clock and synchronous active-low reset
//   start, target_id     begin a load for SM target_id (ignored while busy)
//   abort                array violation; cancels any load in progress
//   kd_req, kd_id        one-cycle request pulse and ID to derive for
//   kd_valid, kd_data,
//   kd_last, kd_ready    key word stream (valid/ready), word 0 first
//   spm_key_select       SM ID addressed by the key write
//   write_key, key_in,
//   key_idx              key word write strobe, data and word index
//   busy                 high whenever the loader is not IDLE
//   done, error          one-cycle completion / failure pulses
// -----------------------------------------------------------------------------
module omsp_spm_key_loader
  import omsp_spm_key_loader_pkg::*;
#(
  parameter int SECURITY     = SPM_SECURITY,
  parameter int KEY_IDX_SIZE = 2,
  parameter int TIMEOUT      = KL_TIMEOUT
) (
  input  logic                    mclk,
  input  logic                    puc_rst_n,
  input  logic                    start,
  input  logic [15:0]             target_id,
  input  logic                    abort,
  output logic                    kd_req,
  output logic [15:0]             kd_id,
  input  logic                    kd_valid,
  input  logic [15:0]             kd_data,
  input  logic                    kd_last,
  output logic                    kd_ready,
  output logic [15:0]             spm_key_select,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int                      NUM_WORDS   = key_words(SECURITY);
  localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX    = KEY_IDX_SIZE'(NUM_WORDS - 1);
  localparam logic [TIMER_W-1:0]      TIMEOUT_VAL = TIMER_W'(TIMEOUT);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  kl_state_t               state_reg, state_next;
  logic [KEY_IDX_SIZE-1:0] word_cnt_reg, word_cnt_next;
  logic [TIMER_W-1:0]      idle_cnt_reg, idle_cnt_next;
  logic [15:0]             id_reg, id_next;
  logic                    write_reg, write_next;
  logic [15:0]             key_in_reg, key_in_next;
  logic [KEY_IDX_SIZE-1:0] key_idx_reg, key_idx_next;
  logic                    error_reg, error_next;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic start_ok;
  logic in_load;
  logic active;
  logic accept;
  logic last_slot;
  logic word_ok;
  logic word_bad;
  logic timeout_hit;

  assign start_ok  = (state_reg == ST_IDLE) && start && !abort;
  assign in_load   = (state_reg == ST_LOAD);
  assign active    = (state_reg != ST_IDLE);
  assign accept    = kd_ready && kd_valid;
  assign last_slot = (word_cnt_reg == LAST_IDX);
  assign word_ok   = accept && word_is_legal(kd_last, last_slot);
  assign word_bad  = accept && !word_is_legal(kd_last, last_slot);

  // The counter reads TIMEOUT after that many idle cycles; one more idle
  // cycle on top of that gives up. A word arriving in that cycle still wins.
  assign timeout_hit = in_load && !abort && !accept && (idle_cnt_reg == TIMEOUT_VAL);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        state_next = abort ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        if (abort || timeout_hit || word_bad) begin
          state_next = ST_IDLE;
        end else if (word_ok && kd_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // abort acts combinationally: it drops kd_ready so no word is taken, hides
  // a write strobe registered the cycle before, and suppresses done.
  // ---------------------------------------------------------------------------
  always_comb begin
    kd_req         = (state_reg == ST_REQ) && !abort;
    kd_ready       = in_load && !abort;
    busy           = active;
    done           = (state_reg == ST_DONE) && !abort;
    write_key      = write_reg && !abort;
    key_in         = key_in_reg;
    key_idx        = key_idx_reg;
    kd_id          = id_reg;
    spm_key_select = id_reg;
    error          = error_reg;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    id_next       = id_reg;
    word_cnt_next = word_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    write_next    = word_ok;
    key_in_next   = key_in_reg;
    key_idx_next  = key_idx_reg;
    error_next    = (active && abort) || timeout_hit || word_bad;

    // A new load starts from a clean slate; the ID then stays put until
    // the next accepted start.
    if (start_ok) begin
      id_next       = target_id;
      word_cnt_next = '0;
      idle_cnt_next = '0;
    end

    // Only well-formed words reach the array. The count never advances
    // past the final slot, so key_idx cannot wrap within a load.
    if (word_ok) begin
      key_in_next  = kd_data;
      key_idx_next = word_cnt_reg;
      if (!kd_last) begin
        word_cnt_next = word_cnt_reg + 1'b1;
      end
    end

    if (in_load) begin
      if (accept) begin
        idle_cnt_next = '0;
      end else if (!timeout_hit) begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      word_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      id_reg       <= '0;
      write_reg    <= 1'b0;
      key_in_reg   <= '0;
      key_idx_reg  <= '0;
      error_reg    <= 1'b0;
    end else begin
      word_cnt_reg <= word_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      id_reg       <= id_next;
      write_reg    <= write_next;
      key_in_reg   <= key_in_next;
      key_idx_reg  <= key_idx_next;
      error_reg    <= error_next;
    end
  end

endmodule

// File: tb/tb_omsp_spm_key_loader.sv
// -----------------------------------------------------------------------------
// tb_omsp_spm_key_loader
//
// Each scenario is described at transaction level (word gap, word count,
// where kd_last / abort / reset land). A planner turns that description into
// a per-cycle input table and a per-cycle table of required outputs, derived
// from the loader's rules with plain cycle arithmetic. One process drives the
// inputs, one compares every output on every cycle. Event tallies and a few
// hand-computed literals at the end pin the planner itself.
//
// Cycle n is the interval after the n-th rising edge; inputs for cycle n are
// applied 1 ns after that edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_omsp_spm_key_loader;

  localparam int KW      = 4;
  localparam int TIMEOUT = 255;
  localparam int NCYC    = 1024;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        start;
  logic [15:0] target_id;
  logic        abort;
  logic        kd_req;
  logic [15:0] kd_id;
  logic        kd_valid;
  logic [15:0] kd_data;
  logic        kd_last;
  logic        kd_ready;
  logic [15:0] spm_key_select;
  logic        write_key;
  logic [15:0] key_in;
  logic [1:0]  key_idx;
  logic        busy;
  logic        done;
  logic        error;

  omsp_spm_key_loader #(
    .SECURITY    (64),
    .KEY_IDX_SIZE(2),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .mclk          (mclk),
    .puc_rst_n     (puc_rst_n),
    .start         (start),
    .target_id     (target_id),
    .abort         (abort),
    .kd_req        (kd_req),
    .kd_id         (kd_id),
    .kd_valid      (kd_valid),
    .kd_data       (kd_data),
    .kd_last       (kd_last),
    .kd_ready      (kd_ready),
    .spm_key_select(spm_key_select),
    .write_key     (write_key),
    .key_in        (key_in),
    .key_idx       (key_idx),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 mclk = ~mclk;

  // Stimulus table
  logic        in_rst_n [NCYC];
  logic        in_start [NCYC];
  logic [15:0] in_tid   [NCYC];
  logic        in_abort [NCYC];
  logic        in_valid [NCYC];
  logic [15:0] in_data  [NCYC];
  logic        in_last  [NCYC];

  // Required-output table
  logic        e_busy  [NCYC];
  logic        e_req   [NCYC];
  logic        e_ready [NCYC];
  logic        e_wr    [NCYC];
  logic [15:0] e_kin   [NCYC];
  logic [1:0]  e_kidx  [NCYC];
  logic        e_done  [NCYC];
  logic        e_err   [NCYC];
  logic        e_zero  [NCYC];
  logic [15:0] e_id    [NCYC];

  int          plan_cyc;
  logic [15:0] cur_id;
  int          cyc;
  bit          running;
  int          n_tests;
  int          n_fail;

  // DUT event tallies
  int          n_wr, n_done, n_err, n_req, last_req;
  logic [15:0] cap_kin [4];
  logic [1:0]  cap_idx [4];
  int          err_dist [$];

  function automatic void chk(input string name, input int c,
                              input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, c, got, exp);
    end
  endfunction

  // Build stimulus and required outputs for one load attempt.
  // Word k is offered k*(gap+1)+gap cycles after LOAD is entered.
  task automatic plan_load(input int gap, input int n_words, input int last_at,
                           input int abort_at, input int rst_at, input bit start_abort,
                           input logic [15:0] id, input logic [15:0] base,
                           input logic [15:0] step);
    int          s, l, c, t, end_c;
    bit          did_rst;
    logic [15:0] old_id, w;
    s       = plan_cyc;
    old_id  = cur_id;
    did_rst = 1'b0;
    in_start[s] = 1'b1;
    in_tid[s]   = id;
    e_id[s]     = old_id;
    if (start_abort) begin
      in_abort[s] = 1'b1;
      for (int x = s + 1; x < s + 4; x++) e_id[x] = old_id;
      plan_cyc = s + 4;
      return;
    end
    e_req[s+1]  = 1'b1;
    e_busy[s+1] = 1'b1;
    l     = s + 2;
    c     = l;
    end_c = -1;
    for (int k = 0; k < n_words && end_c < 0; k++) begin
      t = l + k * (gap + 1) + gap;
      for (int x = c; x < t; x++) begin
        e_busy[x]  = 1'b1;
        e_ready[x] = 1'b1;
      end
      w           = base + 16'(step * k);
      in_valid[t] = 1'b1;
      in_data[t]  = w;
      in_last[t]  = (k == last_at);
      e_busy[t]   = 1'b1;
      if (k == rst_at) begin
        in_rst_n[t]  = 1'b0;
        e_ready[t]   = 1'b1;
        e_zero[t+1]  = 1'b1;
        end_c        = t + 1;
        did_rst      = 1'b1;
      end else if (k == abort_at) begin
        in_abort[t] = 1'b1;
        e_wr[t]     = 1'b0;
        e_err[t+1]  = 1'b1;
        end_c       = t + 1;
      end else begin
        e_ready[t] = 1'b1;
        if ((k == last_at) != (k == KW - 1)) begin
          e_err[t+1] = 1'b1;
          end_c      = t + 1;
        end else begin
          e_wr[t+1]   = 1'b1;
          e_kin[t+1]  = w;
          e_kidx[t+1] = 2'(k);
          if (k == last_at) begin
            e_done[t+1] = 1'b1;
            e_busy[t+1] = 1'b1;
            end_c       = t + 2;
          end else begin
            c = t + 1;
          end
        end
      end
    end
    if (end_c < 0) begin
      for (int x = c; x <= c + TIMEOUT; x++) begin
        e_busy[x]  = 1'b1;
        e_ready[x] = 1'b1;
      end
      e_err[c+TIMEOUT+1] = 1'b1;
      end_c = c + TIMEOUT + 1;
    end
    for (int x = s + 1; x < end_c; x++) e_id[x] = id;
    cur_id   = did_rst ? 16'h0000 : id;
    plan_cyc = end_c + 3;
    for (int x = end_c; x < plan_cyc; x++) e_id[x] = cur_id;
  endtask

  task automatic apply(input int n);
    puc_rst_n = in_rst_n[n];
    start     = in_start[n];
    target_id = in_tid[n];
    abort     = in_abort[n];
    kd_valid  = in_valid[n];
    kd_data   = in_data[n];
    kd_last   = in_last[n];
  endtask

  // Per-cycle compare and event tally
  always @(negedge mclk) begin
    if (running && cyc >= 1) begin
      chk("busy",           cyc, 32'(busy),           32'(e_busy[cyc]));
      chk("kd_req",         cyc, 32'(kd_req),         32'(e_req[cyc]));
      chk("kd_ready",       cyc, 32'(kd_ready),       32'(e_ready[cyc]));
      chk("write_key",      cyc, 32'(write_key),      32'(e_wr[cyc]));
      chk("done",           cyc, 32'(done),           32'(e_done[cyc]));
      chk("error",          cyc, 32'(error),          32'(e_err[cyc]));
      chk("kd_id",          cyc, 32'(kd_id),          32'(e_id[cyc]));
      chk("spm_key_select", cyc, 32'(spm_key_select), 32'(e_id[cyc]));
      if (e_wr[cyc] || e_zero[cyc]) begin
        chk("key_in",  cyc, 32'(key_in),  32'(e_zero[cyc] ? 16'h0000 : e_kin[cyc]));
        chk("key_idx", cyc, 32'(key_idx), 32'(e_zero[cyc] ? 2'd0 : e_kidx[cyc]));
      end
      if (write_key === 1'b1) begin
        if (n_wr < 4) begin
          cap_kin[n_wr] = key_in;
          cap_idx[n_wr] = key_idx;
        end
        n_wr++;
      end
      if (kd_req === 1'b1) begin
        last_req = cyc;
        n_req++;
      end
      if (error === 1'b1) begin
        n_err++;
        err_dist.push_back(cyc - last_req);
      end
      if (done === 1'b1) n_done++;
    end
  end

  initial begin
    logic [15:0] nom_kin [4];
    int          exp_dist [4];
    nom_kin  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp_dist = '{3, 5, 257, 4};
    n_tests = 0; n_fail = 0; running = 1'b0; cyc = 0;
    n_wr = 0; n_done = 0; n_err = 0; n_req = 0; last_req = 0;
    for (int i = 0; i < NCYC; i++) begin
      in_rst_n[i] = 1'b1; in_start[i] = 1'b0; in_tid[i] = '0; in_abort[i] = 1'b0;
      in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0;
      e_busy[i] = 1'b0; e_req[i] = 1'b0; e_ready[i] = 1'b0; e_wr[i] = 1'b0;
      e_kin[i] = '0; e_kidx[i] = '0; e_done[i] = 1'b0; e_err[i] = 1'b0;
      e_zero[i] = 1'b0; e_id[i] = '0;
    end
    // Power-up reset for two cycles; outputs must read zero afterwards.
    in_rst_n[0] = 1'b0; in_rst_n[1] = 1'b0;
    e_zero[1] = 1'b1; e_zero[2] = 1'b1;
    cur_id   = 16'h0000;
    plan_cyc = 3;
    //        gap words last abort rst st+ab id        base      step
    plan_load(0,  4,    3,   -1,   -1, 1'b0, 16'h0003, 16'h1111, 16'h1111); // nominal
    plan_load(5,  4,    3,   -1,   -1, 1'b0, 16'h0005, 16'hA000, 16'h0101); // stalled stream
    plan_load(0,  2,    1,   -1,   -1, 1'b0, 16'h0007, 16'hB000, 16'h0001); // early kd_last
    plan_load(0,  4,   -1,   -1,   -1, 1'b0, 16'h0008, 16'hC000, 16'h0001); // missing kd_last
    plan_load(0,  0,   -1,   -1,   -1, 1'b0, 16'h0004, 16'h0000, 16'h0000); // timeout
    plan_load(0,  4,    3,    2,   -1, 1'b0, 16'h0006, 16'hD000, 16'h0010); // abort mid-stream
    plan_load(0,  0,   -1,   -1,   -1, 1'b1, 16'h00EE, 16'h0000, 16'h0000); // start with abort
    plan_load(0,  4,    3,   -1,    2, 1'b0, 16'h000A, 16'hE000, 16'h0001); // reset in LOAD
    plan_load(0,  4,    3,   -1,   -1, 1'b0, 16'h0009, 16'h5A5A, 16'h1000); // reload after reset

    apply(0);
    running = 1'b1;
    for (int n = 1; n < plan_cyc; n++) begin
      @(posedge mclk);
      cyc = n;
      #1 apply(n);
    end
    @(posedge mclk);
    running = 1'b0;

    // Hand-computed totals over the whole run.
    chk("total_writes", plan_cyc, 32'(n_wr),   32'd19);
    chk("total_done",   plan_cyc, 32'(n_done), 32'd3);
    chk("total_error",  plan_cyc, 32'(n_err),  32'd4);
    chk("total_kd_req", plan_cyc, 32'(n_req),  32'd8);
    // Nominal load writes 0x1111..0x4444 at indices 0..3.
    for (int i = 0; i < 4; i++) begin
      chk("nominal_key_in",  i, 32'(cap_kin[i]), 32'(nom_kin[i]));
      chk("nominal_key_idx", i, 32'(cap_idx[i]), i);
    end
    // Error distance from kd_req: early last, missing last, timeout, abort.
    chk("error_count_seen", plan_cyc, 32'(err_dist.size()), 32'd4);
    for (int i = 0; i < 4 && i < err_dist.size(); i++) begin
      chk("error_latency", i, 32'(err_dist[i]), 32'(exp_dist[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/omsp_spm_key_loader.md
Name: omsp_spm_key_loader

Overview:
- Sequences loading of a freshly derived SM key into the SPM array after a protect operation completes.
- Requests a key from the key-derivation unit and accepts its 16-bit word stream over a valid/ready handshake.
- Drives the array's key_select/write_key/key_in/key_idx write port one word per cycle, and reports done or error to the execution unit.
- Sits between the key-derivation unit and omsp_spm_control; it is the only writer of the key port.

Parameters:
- SECURITY, 64, key width in bits; multiple of 16, at least 32.
- KEY_IDX_SIZE, 2, width of key_idx; equals clog2(SECURITY/16).
- TIMEOUT, 255, maximum idle cycles in LOAD before error; 8-bit counter.

Ports:
- mclk  in  1  clock
- puc_rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse: load key for target_id
- target_id  in  16  ID of the newly protected SM
- abort  in  1  array violation; cancels any load
- kd_req  out  1  one-cycle request pulse to the key-derivation unit
- kd_id  out  16  ID the key is derived for
- kd_valid  in  1  key word valid
- kd_data  in  16  key word; word 0 first, most significant
- kd_last  in  1  final word marker
- kd_ready  out  1  loader accepts a word
- spm_key_select  out  16  SM ID addressed for the write
- write_key  out  1  key word write strobe
- key_in  out  16  key word to the array
- key_idx  out  KEY_IDX_SIZE  word index within the key
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle success pulse
- error  out  1  one-cycle failure pulse

Behaviour:
- Reset: when puc_rst_n is low at a clock edge, state goes to IDLE. Every output resets to 0. Word and timeout counters reset to 0.
- Reset mid-load abandons the load. Partial key words already in the array are not scrubbed by this block.
- States: IDLE, REQ, LOAD, DONE.
- IDLE:
  - On start=1 and abort=0: latch target_id into kd_id and spm_key_select, go to REQ.
  - If start and abort are asserted together, start is ignored.
- REQ: kd_req=1 for exactly one cycle, then go to LOAD.
- LOAD:
  - kd_ready=1 in this state only.
  - Handshake: a word transfers when kd_valid and kd_ready are both 1.
  - On each transfer, write_key, key_in=kd_data and key_idx=word count are registered. The write strobe appears one cycle after the transfer and lasts one cycle. The word count then increments.
  - Back-to-back words are allowed: one per cycle, with no bubble.
- Last-word rules:
  - kd_last with count = SECURITY/16-1: the write is issued, then go to DONE.
  - kd_last with any other count: go to IDLE, error pulse, no write issued for that word.
  - count = SECURITY/16-1 without kd_last: also an error.
- Timeout: the counter increments on each LOAD cycle without a transfer and clears on each transfer. Reaching TIMEOUT gives an error pulse and a return to IDLE.
- DONE: done=1 for one cycle, then go to IDLE. The final write_key strobe coincides with done.
- abort in REQ, LOAD or DONE:
  - Go to IDLE next cycle, with error=1 for one cycle.
  - kd_ready drops the same cycle; a transfer offered that cycle is not accepted.
  - No write strobe is issued after abort is seen; a strobe already registered is suppressed.
  - done is not pulsed.
- start while busy is ignored; no queueing.
- spm_key_select and kd_id hold stable from REQ until the next start. They are cleared only by reset.
- key_idx uses no wrap-around: at most SECURITY/16 writes per load.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, REQ=1, LOAD=2, DONE=3)
  - KEY_WORDS = SECURITY/16
  - the SECURITY define already used by the SPM array
- No sub-module; a single FSM with counters is sufficient.

Test Plan:
- Nominal load: start with target_id=0x0003, then 4 back-to-back words 0x1111, 0x2222, 0x3333, 0x4444 with kd_last on word 3. Expected:
  - kd_req pulses once; kd_id = spm_key_select = 0x0003.
  - write_key fires on 4 consecutive cycles with key_idx 0..3 and the matching key_in.
  - done pulses once, aligned with the last strobe; error stays 0.
- Stalled stream: kd_valid gaps of 5 cycles between words → writes follow each handshake by one cycle, done pulses, no error.
- Early kd_last: kd_last on word 1 → exactly 1 write strobe (idx 0), error pulse, busy=0 next cycle.
- Timeout: no kd_valid after REQ → error exactly TIMEOUT+1 cycles after entering LOAD, with no writes.
- Abort mid-stream: abort in the cycle word 2 is offered → word 2 not accepted, no further write_key, error pulse, done=0.
- Reset and start edge cases:
  - start together with abort in IDLE → no kd_req.
  - puc_rst_n low during LOAD → all outputs 0 next cycle.
  - A new start afterwards loads normally.
